cpu_datapath: RTL and testbench

Register-transfer datapath for the accumulator CPU. It holds PC, MAR, MDR, IR and ACC plus the two-function ALU, and executes the load and mux strobes issued by the `control` sequencer one clock at a time. It returns the opcode and the accumulator-zero flag to `control` and drives the instruction/data memory port. A memory-ready handshake stretches MDR loads and raises `o_stall` so the sequencer can freeze.

---
 rtl/cpu_datapath_if.sv | 51 +++++
 rtl/cpu_datapath.sv | 102 ++++++++++
 tb/tb_cpu_datapath.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_datapath_if.sv
// Purpose : bundles the sequencer strobes, the memory port and the status/debug
//           outputs of the accumulator-CPU datapath into one port.
// Ports   : slave modport = datapath side, master modport = sequencer/memory side.
interface cpu_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    // Memory word is {opcode[7:0], operand[ADDR_W-1:0]}.
    localparam int MEM_W = 8 + ADDR_W;

    // register load strobes and mux/ALU selects
    logic              i_ld_pc;
    logic              i_ld_mar;
    logic              i_ld_mdr;
    logic              i_ld_ir;
    logic              i_ld_acc;
    logic              i_mux_pc_sel;
    logic              i_mux_acc_sel;
    logic              i_mux_mar_sel;
    logic              i_alu_ctrl;
    // memory port
    logic              i_mem_rw;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [MEM_W-1:0]  o_mem_wdata;
    logic              o_mem_we;
    logic [MEM_W-1:0]  i_mem_rdata;
    logic              i_mem_ready;
    // status back to the sequencer, plus debug views
    logic [7:0]        o_opcode;
    logic              o_acc_zero;
    logic              o_carry;
    logic              o_stall;
    logic [ADDR_W-1:0] o_pc;
    logic [DATA_W-1:0] o_acc;

    modport slave (
        input  i_ld_pc, i_ld_mar, i_ld_mdr, i_ld_ir, i_ld_acc,
        input  i_mux_pc_sel, i_mux_acc_sel, i_mux_mar_sel, i_alu_ctrl,
        input  i_mem_rw, i_mem_rdata, i_mem_ready,
        output o_mem_addr, o_mem_wdata, o_mem_we,
        output o_opcode, o_acc_zero, o_carry, o_stall, o_pc, o_acc
    );

    modport master (
        output i_ld_pc, i_ld_mar, i_ld_mdr, i_ld_ir, i_ld_acc,
        output i_mux_pc_sel, i_mux_acc_sel, i_mux_mar_sel, i_alu_ctrl,
        output i_mem_rw, i_mem_rdata, i_mem_ready,
        input  o_mem_addr, o_mem_wdata, o_mem_we,
        input  o_opcode, o_acc_zero, o_carry, o_stall, o_pc, o_acc
    );
endinterface

// File: rtl/cpu_datapath.sv
// Purpose : PC/MAR/MDR/IR/ACC register-transfer datapath with ADD/XOR ALU for the accumulator CPU.
// Latency : register loads visible 1 cycle after the strobe; status/memory outputs combinational from registers.
// Backpressure: MDR loads wait on i_mem_ready (IDLE/WAIT handshake); o_stall tells the sequencer to freeze.
// Ports   : i_clk, i_rst_n (async active-low) plus the cpu_datapath_if slave modport.
module cpu_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    cpu_datapath_if.slave  bus
);
    localparam int MEM_W = 8 + ADDR_W;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} mdr_st_e;

    mdr_st_e           st_q,    st_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [ADDR_W-1:0] mar_q,   mar_d;
    logic [MEM_W-1:0]  mdr_q,   mdr_d;
    logic [MEM_W-1:0]  ir_q,    ir_d;
    logic [DATA_W-1:0] acc_q,   acc_d;
    logic              carry_q, carry_d;

    logic [ADDR_W-1:0] ir_operand;
    logic [DATA_W-1:0] mdr_lo;
    logic [DATA_W:0]   alu_sum;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              rd_req;
    logic              rd_stall;
    logic              mdr_cap;

    always_comb begin
        ir_operand = ir_q[ADDR_W-1:0];
        mdr_lo     = mdr_q[DATA_W-1:0];
        alu_sum    = {1'b0, acc_q} + {1'b0, mdr_lo};
        alu_res    = bus.i_alu_ctrl ? (acc_q ^ mdr_lo) : alu_sum[DATA_W-1:0];
        alu_carry  = ~bus.i_alu_ctrl & alu_sum[DATA_W];

        // In WAIT the read is already outstanding, so a held i_ld_mdr adds nothing.
        rd_req   = (st_q == ST_WAIT) | bus.i_ld_mdr;
        mdr_cap  = rd_req & bus.i_mem_ready;
        // Stall only while data is still missing; the cycle that brings ready is not a stall.
        rd_stall = rd_req & ~bus.i_mem_ready;

        st_d    = rd_stall ? ST_WAIT : ST_IDLE;
        pc_d    = pc_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        carry_d = carry_q;

        // All next values come from pre-edge registers, so simultaneous strobes see old data.
        if (bus.i_ld_pc)
            pc_d = bus.i_mux_pc_sel ? (pc_q + ADDR_W'(1)) : ir_operand;
        if (bus.i_ld_mar)
            mar_d = bus.i_mux_mar_sel ? ir_operand : pc_q;
        if (mdr_cap)
            mdr_d = bus.i_mem_rdata;
        if (bus.i_ld_ir)
            ir_d = mdr_q;
        if (bus.i_ld_acc) begin
            acc_d = bus.i_mux_acc_sel ? alu_res : mdr_lo;
            // Carry tracks ALU loads only; a plain MDR load leaves it alone.
            if (bus.i_mux_acc_sel)
                carry_d = alu_carry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q    <= ST_IDLE;
            pc_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign bus.o_mem_addr  = mar_q;
    assign bus.o_mem_wdata = MEM_W'(acc_q);
    // A write is held off only by an outstanding read; a write waiting on ready keeps we high.
    assign bus.o_mem_we    = bus.i_mem_rw & ~rd_stall;
    assign bus.o_stall     = rd_stall | (bus.i_mem_rw & ~bus.i_mem_ready);
    assign bus.o_opcode    = ir_q[MEM_W-1:ADDR_W];
    assign bus.o_acc_zero  = (acc_q == '0);
    assign bus.o_carry     = carry_q;
    assign bus.o_pc        = pc_q;
    assign bus.o_acc       = acc_q;
endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_datapath_if #(.DATA_W(8), .ADDR_W(8)) bus();
    cpu_datapath #(.DATA_W(8), .ADDR_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    logic [15:0] mem [256];
    assign bus.i_mem_rdata = mem[bus.o_mem_addr];

    int checks = 0;
    int errors = 0;

    // Reference model state as plain integers.
    int m_pc, m_mar, m_mdr, m_ir, m_acc, m_carry, m_wait;
    // Combinational outputs sampled mid-cycle by the last step.
    logic        last_stall, last_we;
    logic [15:0] last_wdata;
    int          stall_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".pc"},    32'(bus.o_pc),       32'(m_pc));
        chk({tag, ".addr"},  32'(bus.o_mem_addr), 32'(m_mar));
        chk({tag, ".opcode"},32'(bus.o_opcode),   32'(m_ir / 256));
        chk({tag, ".acc"},   32'(bus.o_acc),      32'(m_acc));
        chk({tag, ".zero"},  32'(bus.o_acc_zero), 32'(m_acc == 0));
        chk({tag, ".carry"}, 32'(bus.o_carry),    32'(m_carry));
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model, check registers after the edge.
    task automatic step();
        int lo, tot, res, c;
        int n_pc, n_mar, n_mdr, n_ir, n_acc, n_carry;
        bit rd_stall, cap;
        @(negedge clk);
        rd_stall = (m_wait != 0 || bus.i_ld_mdr) && !bus.i_mem_ready;
        cap      = (m_wait != 0 || bus.i_ld_mdr) &&  bus.i_mem_ready;
        last_stall = bus.o_stall;
        last_we    = bus.o_mem_we;
        last_wdata = bus.o_mem_wdata;
        chk("stall", 32'(bus.o_stall),     32'(rd_stall || (bus.i_mem_rw && !bus.i_mem_ready)));
        chk("we",    32'(bus.o_mem_we),    32'(bus.i_mem_rw && !rd_stall));
        chk("wdata", 32'(bus.o_mem_wdata), 32'(m_acc));

        lo = m_mdr % 256;
        if (!bus.i_alu_ctrl) begin
            tot = m_acc + lo;
            res = tot % 256;
            c   = tot / 256;
        end else begin
            res = m_acc ^ lo;
            c   = 0;
        end
        n_pc    = bus.i_ld_pc  ? (bus.i_mux_pc_sel  ? (m_pc + 1) % 256 : m_ir % 256) : m_pc;
        n_mar   = bus.i_ld_mar ? (bus.i_mux_mar_sel ? m_ir % 256 : m_pc) : m_mar;
        n_mdr   = cap ? int'(mem[m_mar]) : m_mdr;
        n_ir    = bus.i_ld_ir ? m_mdr : m_ir;
        n_acc   = bus.i_ld_acc ? (bus.i_mux_acc_sel ? res : lo) : m_acc;
        n_carry = (bus.i_ld_acc && bus.i_mux_acc_sel) ? c : m_carry;

        @(posedge clk);
        #1;
        m_pc = n_pc; m_mar = n_mar; m_mdr = n_mdr; m_ir = n_ir;
        m_acc = n_acc; m_carry = n_carry; m_wait = rd_stall ? 1 : 0;
        check_regs("post");
    endtask

    task automatic drive(input bit ld_pc, input bit ld_mar, input bit ld_mdr, input bit ld_ir,
                         input bit ld_acc, input bit pc_sel, input bit acc_sel, input bit mar_sel,
                         input bit alu, input bit rw, input bit rdy);
        bus.i_ld_pc = ld_pc;     bus.i_ld_mar = ld_mar;     bus.i_ld_mdr = ld_mdr;
        bus.i_ld_ir = ld_ir;     bus.i_ld_acc = ld_acc;     bus.i_mux_pc_sel = pc_sel;
        bus.i_mux_acc_sel = acc_sel; bus.i_mux_mar_sel = mar_sel; bus.i_alu_ctrl = alu;
        bus.i_mem_rw = rw;       bus.i_mem_ready = rdy;
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h00] = 16'h0110;
        mem[8'h10] = 16'h00F0;
        mem[8'h01] = 16'h0020;
        mem[8'h02] = 16'h0010;
        mem[8'h03] = 16'hABCD;
        mem[8'h04] = 16'h00FF;
        mem[8'hFF] = 16'h003C;
        bus.i_ld_pc = 0; bus.i_ld_mar = 0; bus.i_ld_mdr = 0; bus.i_ld_ir = 0; bus.i_ld_acc = 0;
        bus.i_mux_pc_sel = 0; bus.i_mux_acc_sel = 0; bus.i_mux_mar_sel = 0; bus.i_alu_ctrl = 0;
        bus.i_mem_rw = 0; bus.i_mem_ready = 1;
        m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_acc = 0; m_carry = 0; m_wait = 0;

        // Reset state
        #1;
        check_regs("reset");
        chk("reset.stall", 32'(bus.o_stall), 32'd0);
        chk("reset.we",    32'(bus.o_mem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fetch
        drive(0,1,0,0,0, 0,0,0,0,0,1);
        chk("fetch.mar", 32'(bus.o_mem_addr), 32'h00);
        drive(0,0,1,0,0, 0,0,0,0,0,1);
        drive(0,0,0,1,0, 0,0,0,0,0,1);
        chk("fetch.opcode", 32'(bus.o_opcode), 32'h01);
        drive(0,1,0,0,0, 0,0,1,0,0,1);
        chk("fetch.operand", 32'(bus.o_mem_addr), 32'h10);
        drive(1,0,0,0,0, 1,0,0,0,0,1);
        chk("fetch.pc", 32'(bus.o_pc), 32'h01);

        // ADD wrap, then XOR to zero
        drive(0,0,1,0,0, 0,0,0,0,0,1);
        drive(0,0,0,0,1, 0,0,0,0,0,1);
        chk("add.acc_f0", 32'(bus.o_acc), 32'hF0);
        drive(0,1,0,0,0, 0,0,0,0,0,1);
        drive(0,0,1,0,0, 0,0,0,0,0,1);
        drive(0,0,0,0,1, 0,1,0,0,0,1);
        chk("add.acc",   32'(bus.o_acc),   32'h10);
        chk("add.carry", 32'(bus.o_carry), 32'd1);
        drive(1,0,0,0,0, 1,0,0,0,0,1);
        drive(0,1,0,0,0, 0,0,0,0,0,1);
        drive(0,0,1,0,0, 0,0,0,0,0,1);
        drive(0,0,0,0,1, 0,1,0,1,0,1);
        chk("xor.acc",   32'(bus.o_acc),      32'h00);
        chk("xor.zero",  32'(bus.o_acc_zero), 32'd1);
        chk("xor.carry", 32'(bus.o_carry),    32'd0);

        // Wait states: ld_mdr held through 3 not-ready cycles and the ready cycle
        drive(1,0,0,0,0, 1,0,0,0,0,1);
        drive(0,1,0,0,0, 0,0,0,0,0,1);
        stall_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            drive(0,0,1,0,0, 0,0,0,0,0,0);
            stall_cnt += int'(last_stall);
        end
        drive(0,0,1,0,0, 0,0,0,0,0,1);
        stall_cnt += int'(last_stall);
        chk("wait.stall_cycles", 32'(stall_cnt), 32'd3);
        drive(0,0,0,0,0, 0,0,0,0,0,0);
        chk("wait.no_linger", 32'(last_stall), 32'd0);
        drive(0,0,0,1,0, 0,0,0,0,0,1);
        chk("wait.opcode", 32'(bus.o_opcode), 32'hAB);
        drive(0,0,0,0,1, 0,0,0,0,0,1);
        chk("wait.acc", 32'(bus.o_acc), 32'hCD);

        // PC wrap with simultaneous MAR load
        drive(1,0,0,0,0, 1,0,0,0,0,1);
        drive(0,1,0,0,0, 0,0,0,0,0,1);
        drive(0,0,1,0,0, 0,0,0,0,0,1);
        drive(0,0,0,1,0, 0,0,0,0,0,1);
        drive(1,0,0,0,0, 0,0,0,0,0,1);
        chk("wrap.pc_ff", 32'(bus.o_pc), 32'hFF);
        drive(1,1,0,0,0, 1,0,0,0,0,1);
        chk("wrap.pc",  32'(bus.o_pc),       32'h00);
        chk("wrap.mar", 32'(bus.o_mem_addr), 32'hFF);

        // Write with one wait cycle
        drive(0,0,1,0,0, 0,0,0,0,0,1);
        drive(0,0,0,0,1, 0,0,0,0,0,1);
        chk("write.acc", 32'(bus.o_acc), 32'h3C);
        drive(0,0,0,0,0, 0,0,0,0,1,0);
        chk("write.stall0", 32'(last_stall), 32'd1);
        chk("write.we0",    32'(last_we),    32'd1);
        drive(0,0,0,0,0, 0,0,0,0,1,1);
        chk("write.stall1", 32'(last_stall), 32'd0);
        chk("write.we1",    32'(last_we),    32'd1);
        chk("write.wdata",  32'(last_wdata), 32'h003C);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom % 4 == 0, $urandom % 4 == 0, $urandom % 3 == 0, $urandom % 4 == 0,
                  $urandom % 3 == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom % 5 == 0, $urandom % 3 != 0);
        end

        // Asynchronous reset in the middle of a WAIT with ACC = 0x5A
        drive(0,0,1,0,0, 0,0,0,0,0,1);
        mem[m_mar] = 16'h005A;
        drive(0,0,1,0,0, 0,0,0,0,0,1);
        drive(0,0,0,0,1, 0,0,0,0,0,1);
        chk("rst.acc_5a", 32'(bus.o_acc), 32'h5A);
        drive(0,0,1,0,0, 0,0,0,0,0,0);
        bus.i_ld_mdr = 0;
        bus.i_mem_ready = 0;
        #2;
        chk("rst.pre_stall", 32'(bus.o_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_acc = 0; m_carry = 0; m_wait = 0;
        check_regs("async_rst");
        chk("async_rst.stall", 32'(bus.o_stall),    32'd0);
        chk("async_rst.zero",  32'(bus.o_acc_zero), 32'd1);
        chk("async_rst.we",    32'(bus.o_mem_we),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
